divide_unit: RTL and testbench

- Parametrised multi-cycle integer divider for the MIPS32 core's HI/LO path. Generalises the current fixed 32-bit, 1-bit-per-cycle divider in two ways: operand width is configurable, and 1, 2 or 4 quotient bits are retired per cycle.
- Adds MIPS-correct signed remainders, a divide-by-zero flag, a completion pulse, and an explicit abort.
- Sits beside the multiplier. The pipeline stalls on `stall` and captures results on `done`.

---
 rtl/div_pkg.sv | 29 ++
 rtl/div_step.sv | 24 ++
 rtl/divide_unit.sv | 130 +++++++++++++
 tb/tb_divide_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the HI/LO divider.
// Op kinds, FSM states and elaboration helpers.
package div_pkg;

  typedef enum logic {
    DIV_SIGNED,
    DIV_UNSIGNED
  } op_kind_t;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit bpc_ok(input int bpc,
                                input int width);
    return (bpc == 1 || bpc == 2 || bpc == 4) &&
           (width % bpc == 0) && (width >= 8);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step.
// Shifts in the next dividend bit and tries the subtraction.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] denom,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;

  // A set rem MSB means the shifted value exceeds any denom.
  always_comb begin
    shifted = {rem[WIDTH-2:0], bit_in};
    trial   = {1'b0, shifted} - {1'b0, denom};
    q_bit   = rem[WIDTH-1] | ~trial[WIDTH];
    rem_out = q_bit ? trial[WIDTH-1:0] : shifted;
  end

endmodule

// File: rtl/divide_unit.sv
// Multi-cycle signed/unsigned divider for HI/LO.
// Retires BPC quotient bits per cycle, MSB first.
module divide_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             op_div,
  input  logic             op_divu,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = clog2(N);

  if (!bpc_ok(BPC, WIDTH)) begin : g_bad_cfg
    $error("divide_unit: illegal WIDTH/BPC");
  end

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] num;
  logic [WIDTH-1:0] denom;
  logic [WIDTH-1:0] rem;
  logic             qneg;
  logic             rneg;
  logic             zero;

  logic             start;
  op_kind_t         kind;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] num_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  logic [WIDTH-1:0] rem_c [BPC+1];
  logic [BPC-1:0]   qb;

  assign rem_c[0] = rem;

  for (genvar i = 0; i < BPC; i++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem     (rem_c[i]),
      .bit_in  (num[WIDTH-1-i]),
      .denom   (denom),
      .rem_out (rem_c[i+1]),
      .q_bit   (qb[BPC-1-i])
    );
  end

  // Start decode, operand magnitudes and result sign fix-up.
  // A zero divisor leaves the dividend magnitude in rem,
  // so the rneg fix-up restores the original dividend.
  always_comb begin
    start    = op_div | op_divu;
    kind     = op_div ? DIV_SIGNED : DIV_UNSIGNED;
    a_neg    = (kind == DIV_SIGNED) & dividend[WIDTH-1];
    b_neg    = (kind == DIV_SIGNED) & divisor[WIDTH-1];
    a_mag    = a_neg ? -dividend : dividend;
    b_mag    = b_neg ? -divisor : divisor;
    num_next = {num[WIDTH-BPC-1:0], qb};
    q_fix    = zero ? '1
             : (qneg ? -num_next : num_next);
    r_fix    = rneg ? -rem_c[BPC] : rem_c[BPC];
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      num         <= '0;
      denom       <= '0;
      rem         <= '0;
      qneg        <= 1'b0;
      rneg        <= 1'b0;
      zero        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      stall       <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state       <= BUSY;
        count       <= CW'(N - 1);
        num         <= a_mag;
        denom       <= b_mag;
        rem         <= '0;
        qneg        <= a_neg ^ b_neg;
        rneg        <= a_neg;
        zero        <= (divisor == '0);
        stall       <= 1'b1;
        div_by_zero <= 1'b0;
      end else if (state == BUSY) begin
        if (abort) begin
          state <= IDLE;
          stall <= 1'b0;
        end else begin
          num   <= num_next;
          rem   <= rem_c[BPC];
          count <= count - 1'b1;
          if (count == '0) begin
            state       <= IDLE;
            stall       <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= zero;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_divide_unit.sv
// Self-checking bench for divide_unit.
// Directed vectors, corner sequences and random ops.
module tb_divide_unit;

  logic        clk;
  logic        rst_n;

  logic        d_div, d_divu, d_abort;
  logic [31:0] d_a, d_b;
  logic [31:0] q32, r32;
  logic        st32, dn32, z32;

  logic        s_div, s_divu, s_abort;
  logic [15:0] s_a, s_b;
  logic [15:0] q4, r4, q2, r2;
  logic        st4, dn4, z4, st2, dn2, z2;

  int checks;
  int errors;

  divide_unit #(.WIDTH(32), .BPC(1)) u32 (
    .clock(clk), .reset_n(rst_n),
    .op_div(d_div), .op_divu(d_divu), .abort(d_abort),
    .dividend(d_a), .divisor(d_b),
    .quotient(q32), .remainder(r32),
    .stall(st32), .done(dn32), .div_by_zero(z32)
  );

  divide_unit #(.WIDTH(16), .BPC(4)) u16x4 (
    .clock(clk), .reset_n(rst_n),
    .op_div(s_div), .op_divu(s_divu), .abort(s_abort),
    .dividend(s_a), .divisor(s_b),
    .quotient(q4), .remainder(r4),
    .stall(st4), .done(dn4), .div_by_zero(z4)
  );

  divide_unit #(.WIDTH(16), .BPC(2)) u16x2 (
    .clock(clk), .reset_n(rst_n),
    .op_div(s_div), .op_divu(s_divu), .abort(s_abort),
    .dividend(s_a), .divisor(s_b),
    .quotient(q2), .remainder(r2),
    .stall(st2), .done(dn2), .div_by_zero(z2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    bit          z;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Plain-arithmetic model: truncating division on
  // sign-extended integers, zero-divisor rule on top.
  function automatic void ref_div(input int w,
                                  input bit sgn,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q,
                                  output logic [31:0] r,
                                  output bit z);
    longint m, sa, sb;
    m  = (longint'(1) << w) - 1;
    sa = longint'(a) & m;
    sb = longint'(b) & m;
    if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
    z = (sb == 0);
    if (z) begin
      q = 32'(m);
      r = 32'(longint'(a) & m);
    end else begin
      q = 32'((sa / sb) & m);
      r = 32'((sa % sb) & m);
    end
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 6))
      0: return 16'h0;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h1;
      4: return 16'($urandom_range(0, 20));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic do32(input bit sgn,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] eq,
                      input logic [31:0] er,
                      input bit ez,
                      input string nm);
    int cs, t;
    bit got, gz;
    logic [31:0] gq, gr;
    @(negedge clk);
    d_div = sgn; d_divu = !sgn; d_a = a; d_b = b;
    @(negedge clk);
    d_div = 1'b0; d_divu = 1'b0;
    cs = 0; t = 0; got = 0; gz = 0; gq = '0; gr = '0;
    while (!got && t < 100) begin
      if (dn32) begin
        got = 1; gq = q32; gr = r32; gz = z32;
      end else begin
        if (st32) cs++;
        t++;
        @(negedge clk);
      end
    end
    chk({nm, "_done"}, 32'(got), 32'd1);
    chk({nm, "_stall"}, 32'(cs), 32'd32);
    chk({nm, "_q"}, gq, eq);
    chk({nm, "_r"}, gr, er);
    chk({nm, "_z"}, 32'(gz), 32'(ez));
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(dn32), 32'd0);
  endtask

  initial begin
    int nd, cs, c4, c2, t;
    bit g4, g2, sgn, ez;
    logic [31:0] eq, er, a, b, gq, gr;
    logic [15:0] a16, b16;
    logic [15:0] gq4, gr4, gq2, gr2;
    bit gz4, gz2;

    checks = 0; errors = 0;
    rst_n = 1'b0;
    d_div = 0; d_divu = 0; d_abort = 0; d_a = 0; d_b = 0;
    s_div = 0; s_divu = 0; s_abort = 0; s_a = 0; s_b = 0;

    tbl[0] = '{0, 32'd100, 32'd7, 32'd14, 32'd2, 0};
    tbl[1] = '{1, -32'sd7, 32'd2, 32'hFFFF_FFFD,
               32'hFFFF_FFFF, 0};
    tbl[2] = '{1, 32'd7, -32'sd2, 32'hFFFF_FFFD, 32'd1, 0};
    tbl[3] = '{1, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 32'd0, 0};
    tbl[4] = '{0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1};
    tbl[5] = '{1, -32'sd5, 32'd0, 32'hFFFF_FFFF,
               32'hFFFF_FFFB, 1};

    #12;
    chk("rst_q", q32, 32'd0);
    chk("rst_r", r32, 32'd0);
    chk("rst_stall", 32'(st32), 32'd0);
    chk("rst_done", 32'(dn32), 32'd0);
    chk("rst_z", 32'(z32), 32'd0);
    chk("rst_stall16", 32'({st4, st2}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      do32(tbl[i].sgn, tbl[i].a, tbl[i].b,
           tbl[i].q, tbl[i].r, tbl[i].z,
           $sformatf("vec%0d", i));

    // Async reset between edges mid-operation.
    @(negedge clk);
    d_divu = 1'b1; d_a = 32'd1000; d_b = 32'd3;
    @(negedge clk);
    d_divu = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_q", q32, 32'd0);
    chk("arst_r", r32, 32'd0);
    chk("arst_stall", 32'(st32), 32'd0);
    chk("arst_z", 32'(z32), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Restart at stall cycle 10 with new operands.
    @(negedge clk);
    d_div = 1'b1; d_a = 32'd1000; d_b = 32'd3;
    @(negedge clk);
    d_div = 1'b0;
    repeat (9) @(negedge clk);
    d_divu = 1'b1; d_a = 32'd9; d_b = 32'd3;
    @(negedge clk);
    d_divu = 1'b0;
    nd = 0; cs = 0; gq = '1; gr = '1;
    for (int k = 0; k < 45; k++) begin
      if (dn32) begin
        nd++; gq = q32; gr = r32;
      end
      if (st32) cs++;
      @(negedge clk);
    end
    chk("restart_dones", 32'(nd), 32'd1);
    chk("restart_stall", 32'(cs), 32'd32);
    chk("restart_q", gq, 32'd3);
    chk("restart_r", gr, 32'd0);

    // Abort at stall cycle 10.
    @(negedge clk);
    d_divu = 1'b1; d_a = 32'd1000; d_b = 32'd3;
    @(negedge clk);
    d_divu = 1'b0;
    repeat (9) @(negedge clk);
    d_abort = 1'b1;
    @(negedge clk);
    d_abort = 1'b0;
    chk("abort_stall", 32'(st32), 32'd0);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (dn32 || st32) nd++;
      @(negedge clk);
    end
    chk("abort_nodone", 32'(nd), 32'd0);

    for (int i = 0; i < 200; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = pick32();
      b = pick32();
      ref_div(32, sgn, a, b, eq, er, ez);
      do32(sgn, a, b, eq, er, ez, $sformatf("r32_%0d", i));
    end

    for (int i = 0; i < 3000; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a16 = pick16();
      b16 = pick16();
      ref_div(16, sgn, {16'b0, a16}, {16'b0, b16}, eq, er, ez);
      @(negedge clk);
      s_div = sgn; s_divu = !sgn; s_a = a16; s_b = b16;
      @(negedge clk);
      s_div = 1'b0; s_divu = 1'b0;
      c4 = 0; c2 = 0; g4 = 0; g2 = 0; t = 0;
      gq4 = '0; gr4 = '0; gq2 = '0; gr2 = '0;
      gz4 = 0; gz2 = 0;
      while (!(g4 && g2) && t < 40) begin
        if (!g4) begin
          if (dn4) begin
            g4 = 1; gq4 = q4; gr4 = r4; gz4 = z4;
          end else if (st4) c4++;
        end
        if (!g2) begin
          if (dn2) begin
            g2 = 1; gq2 = q2; gr2 = r2; gz2 = z2;
          end else if (st2) c2++;
        end
        t++;
        if (!(g4 && g2)) @(negedge clk);
      end
      chk($sformatf("b4_done%0d", i), 32'(g4), 32'd1);
      chk($sformatf("b2_done%0d", i), 32'(g2), 32'd1);
      chk($sformatf("b4_stall%0d", i), 32'(c4), 32'd4);
      chk($sformatf("b2_stall%0d", i), 32'(c2), 32'd8);
      chk($sformatf("b4_q%0d", i), {16'b0, gq4}, eq);
      chk($sformatf("b4_r%0d", i), {16'b0, gr4}, er);
      chk($sformatf("b4_z%0d", i), 32'(gz4), 32'(ez));
      chk($sformatf("b2_q%0d", i), {16'b0, gq2}, eq);
      chk($sformatf("b2_r%0d", i), {16'b0, gr2}, er);
      chk($sformatf("b2_z%0d", i), 32'(gz2), 32'(ez));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
